// File: rtl/md_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op codes, FSM states
// and op classification helpers.
package md_pkg;

    localparam logic [3:0] OP_NOP   = 4'd0;
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MADD  = 4'd5;
    localparam logic [3:0] OP_MADDU = 4'd6;
    localparam logic [3:0] OP_MSUB  = 4'd7;
    localparam logic [3:0] OP_MSUBU = 4'd8;
    localparam logic [3:0] OP_MTHI  = 4'd9;
    localparam logic [3:0] OP_MTLO  = 4'd10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2
    } state_e;

    function automatic logic is_multicycle(input logic [3:0] op);
        return (op >= OP_MULT) && (op <= OP_MSUBU);
    endfunction

    function automatic logic is_signed(input logic [3:0] op);
        return (op == OP_MULT) || (op == OP_DIV) || (op == OP_MADD) || (op == OP_MSUB);
    endfunction

    function automatic logic is_div(input logic [3:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/md_iter_unit_div_step.sv
// Combinational restoring-divide slice: STEPS quotient bits per evaluation on
// unsigned magnitudes. The quotient register shifts dividend bits out the top.
module md_div_step #(
    parameter int WIDTH = 32,
    parameter int STEPS = 1
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic [WIDTH-1:0] quo_i,
    input  logic [WIDTH-1:0] div_i,
    output logic [WIDTH-1:0] rem_o,
    output logic [WIDTH-1:0] quo_o
);

    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;

    always_comb begin
        rem   = rem_i;
        quo   = quo_i;
        trial = '0;
        for (int s = 0; s < STEPS; s++) begin
            trial = {rem, quo[WIDTH-1]};
            quo   = {quo[WIDTH-2:0], 1'b0};
            if (trial >= {1'b0, div_i}) begin
                trial  = trial - {1'b0, div_i};
                quo[0] = 1'b1;
            end
            rem = trial[WIDTH-1:0];
        end
        rem_o = rem;
        quo_o = quo;
    end

endmodule

// File: rtl/md_iter_unit.sv
// Iterative multiply/divide unit owning HI/LO. Define MD_EARLY_TERM_EN to let
// multiplies stop on an exhausted multiplier and divides skip leading zero digits.
module md_iter_unit
    import md_pkg::*;
#(
    parameter int WIDTH           = 32,
    parameter int STEPS_PER_CYCLE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             cancel,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int NIT = WIDTH / STEPS_PER_CYCLE;
    localparam int CW  = $clog2(NIT + 1);

    state_e             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplr_q, mplr_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic [3:0]         op_q, op_d;
    logic               neg_q, neg_d, rneg_q, rneg_d, done_q, done_d;

    logic               sa, sb, div_zero, go, launch;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [CW-1:0]      skip;

    always_comb begin
        sa       = is_signed(op) & src_a[WIDTH-1];
        sb       = is_signed(op) & src_b[WIDTH-1];
        mag_a    = sa ? -src_a : src_a;
        mag_b    = sb ? -src_b : src_b;
        div_zero = is_div(op) & (src_b == '0);
        go       = start & ~cancel;
        launch   = go & is_multicycle(op) & ~div_zero;
    end

`ifdef MD_EARLY_TERM_EN
    // Leading all-zero digits of the dividend produce zero quotient digits and
    // leave the remainder at zero, so they can be consumed up front. At least one
    // digit is always left for the RUN state.
    logic zero_run;
    always_comb begin
        skip     = '0;
        zero_run = 1'b1;
        for (int g = NIT - 1; g > 0; g--) begin
            if (zero_run && (mag_a[g*STEPS_PER_CYCLE +: STEPS_PER_CYCLE] == '0))
                skip = skip + 1'b1;
            else
                zero_run = 1'b0;
        end
    end
`else
    assign skip = '0;
`endif

    logic [WIDTH-1:0] dv_rem, dv_quo;

    md_div_step #(
        .WIDTH (WIDTH),
        .STEPS (STEPS_PER_CYCLE)
    ) u_div_step (
        .rem_i (acc_q[2*WIDTH-1:WIDTH]),
        .quo_i (acc_q[WIDTH-1:0]),
        .div_i (mcand_q[WIDTH-1:0]),
        .rem_o (dv_rem),
        .quo_o (dv_quo)
    );

    logic [2*WIDTH-1:0] ml_acc, ml_cand;
    logic [WIDTH-1:0]   ml_plr;

    always_comb begin
        ml_acc  = acc_q;
        ml_cand = mcand_q;
        ml_plr  = mplr_q;
        for (int s = 0; s < STEPS_PER_CYCLE; s++) begin
            if (ml_plr[0])
                ml_acc = ml_acc + ml_cand;
            ml_cand = ml_cand << 1;
            ml_plr  = ml_plr >> 1;
        end
    end

    logic [2*WIDTH-1:0] prod, fix_res;
    logic [WIDTH-1:0]   quo_s, rem_s;

    always_comb begin
        prod  = neg_q  ? -acc_q : acc_q;
        quo_s = neg_q  ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem_s = rneg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
        case (op_q)
            OP_MADD, OP_MADDU: fix_res = {hi_q, lo_q} + prod;
            OP_MSUB, OP_MSUBU: fix_res = {hi_q, lo_q} - prod;
            OP_DIV, OP_DIVU:   fix_res = {rem_s, quo_s};
            default:           fix_res = prod;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        mcand_d = mcand_q;
        mplr_d  = mplr_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        op_d    = op_q;
        neg_d   = neg_q;
        rneg_d  = rneg_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (launch) begin
                    state_d = ST_RUN;
                    op_d    = op;
                    neg_d   = sa ^ sb;
                    rneg_d  = sa;
                    if (is_div(op)) begin
                        acc_d   = {{WIDTH{1'b0}}, mag_a << (skip * STEPS_PER_CYCLE)};
                        mcand_d = {{WIDTH{1'b0}}, mag_b};
                        mplr_d  = '0;
                        cnt_d   = CW'(NIT) - skip;
                    end else begin
                        acc_d   = '0;
                        mcand_d = {{WIDTH{1'b0}}, mag_a};
                        mplr_d  = mag_b;
                        cnt_d   = CW'(NIT);
                    end
                end else if (go && (op == OP_MTHI)) begin
                    hi_d = src_a;
                end else if (go && (op == OP_MTLO)) begin
                    lo_d = src_a;
                end
            end
            ST_RUN: begin
                if (cancel) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                    if (is_div(op_q)) begin
                        acc_d = {dv_rem, dv_quo};
                    end else begin
                        acc_d   = ml_acc;
                        mcand_d = ml_cand;
                        mplr_d  = ml_plr;
                    end
                    if (cnt_d == '0)
                        state_d = ST_FIX;
`ifdef MD_EARLY_TERM_EN
                    if (!is_div(op_q) && (ml_plr == '0))
                        state_d = ST_FIX;
`endif
                end
            end
            ST_FIX: begin
                state_d = ST_IDLE;
                if (!cancel) begin
                    {hi_d, lo_d} = fix_res;
                    done_d       = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            mcand_q <= '0;
            mplr_q  <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            op_q    <= OP_NOP;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            mcand_q <= mcand_d;
            mplr_q  <= mplr_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            op_q    <= op_d;
            neg_q   <= neg_d;
            rneg_q  <= rneg_d;
            done_q  <= done_d;
        end
    end

    assign busy = (state_q != ST_IDLE) | launch;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: doc/md_iter_unit.md
Name: md_iter_unit

Overview:
- Parametrised, iterative successor to the fixed-latency multiply/divide unit in the execute stage.
- Computes mult/multu/div/divu/madd/maddu/msub/msubu with real shift-add and restoring-division datapaths, STEPS_PER_CYCLE bits per clock, instead of a countdown over a combinational result.
- Owns the architectural HI/LO registers and exports a busy signal to the hazard unit.
- Adds a cancel input so an exception flush can abort an in-flight operation without corrupting HI/LO.

Parameters:
- WIDTH, 32: operand width and HI/LO width.
- STEPS_PER_CYCLE, 1: iteration bits per clock. Legal values are 1, 2, 4; must divide WIDTH.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous, active-low.
- start  in  1  issue the operation on op this cycle.
- op  in  4  0 nop, 1 mult, 2 multu, 3 div, 4 divu, 5 madd, 6 maddu, 7 msub, 8 msubu, 9 mthi, 10 mtlo, others nop.
- src_a  in  WIDTH  rs operand.
- src_b  in  WIDTH  rt operand.
- cancel  in  1  abort the in-flight operation and suppress any start this cycle.
- busy  out  1  unit occupied (hazard stall source).
- done  out  1  one-cycle pulse in the cycle HI/LO hold a new multi-cycle result.
- hi  out  WIDTH  architectural HI, registered.
- lo  out  WIDTH  architectural LO, registered.

Behaviour:
- Reset (async, rst_n=0): hi=0, lo=0, done=0, state=IDLE, all working registers cleared, busy=0. Reset mid-operation discards the operation.
- CYC = WIDTH/STEPS_PER_CYCLE + 1 (iterations plus one fix-up cycle). Default CYC=33.
- States:
  - IDLE -> RUN on accepted multi-cycle op; operands, op and sign flags are latched.
  - RUN: iteration counter counts down from WIDTH/STEPS_PER_CYCLE; at 0 -> FIX.
  - FIX: apply signs and accumulate, write hi/lo, done=1 for this cycle -> IDLE.
- busy = (state != IDLE) | (start & ~cancel & op is multi-cycle & not div-by-zero). busy is high combinationally in the issue cycle.
- Latency: start accepted at edge N; new hi/lo visible after edge N+CYC.
- Start while state != IDLE is ignored. The hazard unit guarantees no issue while busy.
- mthi/mtlo with start & ~cancel in IDLE: hi or lo <= src_a at the next edge. No busy, no done.
- Multiply:
  - Signed ops take magnitudes of operands; product is negated in FIX if the signs differ.
  - 2*WIDTH-bit product; hi = upper half, lo = lower half.
- madd/msub: {hi,lo} <= {hi,lo} +/- product, mod 2^(2*WIDTH), using the hi/lo values present in FIX.
- Divide:
  - Restoring division on magnitudes.
  - Quotient sign = sign(a) xor sign(b). Remainder takes the dividend's sign.
  - lo = quotient, hi = remainder.
  - Most-negative / -1: lo = most-negative value (wrap), hi = 0.
- div/divu with src_b = 0: not accepted. No busy, no done, hi/lo unchanged.
- cancel:
  - While in RUN or FIX: go to IDLE at the next edge, hi/lo unchanged, done=0. busy drops the cycle after cancel.
  - Together with start in IDLE: cancel wins and the op is not accepted.
- hi/lo change only in FIX or on mthi/mtlo, never during RUN.

Optional Feature:
- Macro: MD_EARLY_TERM_EN.
- Defined:
  - Multiply jumps to FIX once the remaining multiplier bits are all zero.
  - Divide starts at the first set bit of the dividend magnitude (pre-shift skips leading zeros).
  - Latency is variable, 2..CYC cycles; busy and done follow the real completion.
  - Results are bit-identical to the undefined build.
- Undefined: latency is exactly CYC for every multi-cycle op.

Decomposition:
- Package md_pkg holds:
  - op encoding constants (OP_MULT..OP_MTLO);
  - state encoding (ST_IDLE, ST_RUN, ST_FIX);
  - helpers: is_multicycle(op), is_signed(op).
- Sub-module md_div_step: combinational STEPS_PER_CYCLE-deep restoring-divide step. Inputs: partial remainder, quotient shift register, divisor magnitude. Outputs: next remainder and next quotient.
- Multiplier shift-add stays in the top module.

Test Plan:
- mult src_a=0xFFFFFFFE, src_b=3 -> busy high for 33 cycles from issue; then hi=0xFFFFFFFF, lo=0xFFFFFFFA, done pulses once.
- div src_a=0xFFFFFFF9 (-7), src_b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. Also div 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- mtlo 0xFFFFFFFF, mthi 0, then maddu src_a=1, src_b=1 -> hi=0x00000001, lo=0x00000000. Then msub src_a=1, src_b=1 -> hi=0, lo=0xFFFFFFFF.
- divu src_a=7, src_b=0 -> busy stays 0, done stays 0, hi/lo unchanged. Also start while busy with op=mult is ignored.
- multu 5x5, cancel asserted 10 cycles after issue -> busy 0 from the next cycle, hi/lo keep prior values, done never pulses. Also start+cancel together in IDLE -> nothing accepted.
- WIDTH=16, STEPS_PER_CYCLE=4: divu 1000/7 -> lo=142, hi=6 after CYC=5 cycles. With MD_EARLY_TERM_EN, multu 3x1 completes in fewer than 33 cycles with lo=3.
